wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 111 +++++++++++
 tb/tb_wb_regfile.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile -- write-back stage register plus 32 x 32 register file with two
// combinational read ports and a committed-write counter.
//
// The EX result (regcWr/regcAddr/regcData) is captured unconditionally into
// the WB stage register on every rising edge.  A captured write lands in the
// array one edge later, provided it targets a nonzero register.  Register 0
// always reads as zero.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   -> enabled reads of nonzero registers forward, in priority
//                order: the EX result, then the WB stage, then the array.
//   undefined -> reads return array contents only.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   regcWr    in   1   EX result write enable (1 = enable, 0 = disable)
//   regcAddr  in   5   EX destination register number
//   regcData  in   32  EX result data
//   regaRd    in   1   read port A enable
//   regaAddr  in   5   read port A register number
//   regbRd    in   1   read port B enable
//   regbAddr  in   5   read port B register number
//   regaData  out  32  read port A data (combinational)
//   regbData  out  32  read port B data (combinational)
//   wbCount   out  32  committed register writes, wraps at 2^32
// ---------------------------------------------------------------------------
module wb_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        regcWr,
   input  logic [4:0]  regcAddr,
   input  logic [31:0] regcData,
   input  logic        regaRd,
   input  logic [4:0]  regaAddr,
   input  logic        regbRd,
   input  logic [4:0]  regbAddr,
   output logic [31:0] regaData,
   output logic [31:0] regbData,
   output logic [31:0] wbCount
);

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   logic        wb_wr;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] wb_count;
   logic [31:0] reg_mem [32];

   assign wbCount = wb_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_wr    <= DISABLE;
         wb_addr  <= '0;
         wb_data  <= '0;
         wb_count <= '0;
         for (int i = 0; i < 32; i++) begin
            reg_mem[i] <= '0;
         end
      end else begin
         wb_wr   <= regcWr;
         wb_addr <= regcAddr;
         wb_data <= regcData;
         if (wb_wr == ENABLE && wb_addr != 5'd0) begin
            reg_mem[wb_addr] <= wb_data;
            wb_count         <= wb_count + 32'd1;
         end
      end
   end

   // Reads are gated by rst_n so a forwarded EX value cannot leak out while
   // the block is held in reset.
   always_comb begin
      regaData = '0;
      if (rst_n && regaRd == ENABLE && regaAddr != 5'd0) begin
`ifdef WB_BYPASS_EN
         if (regcWr == ENABLE && regcAddr == regaAddr) begin
            regaData = regcData;
         end else if (wb_wr == ENABLE && wb_addr == regaAddr) begin
            regaData = wb_data;
         end else begin
            regaData = reg_mem[regaAddr];
         end
`else
         regaData = reg_mem[regaAddr];
`endif
      end
   end

   always_comb begin
      regbData = '0;
      if (rst_n && regbRd == ENABLE && regbAddr != 5'd0) begin
`ifdef WB_BYPASS_EN
         if (regcWr == ENABLE && regcAddr == regbAddr) begin
            regbData = regcData;
         end else if (wb_wr == ENABLE && wb_addr == regbAddr) begin
            regbData = wb_data;
         end else begin
            regbData = reg_mem[regbAddr];
         end
`else
         regbData = reg_mem[regbAddr];
`endif
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        regcWr;
   logic [4:0]  regcAddr;
   logic [31:0] regcData;
   logic        regaRd;
   logic [4:0]  regaAddr;
   logic        regbRd;
   logic [4:0]  regbAddr;
   logic [31:0] regaData;
   logic [31:0] regbData;
   logic [31:0] wbCount;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .regcWr   (regcWr),
      .regcAddr (regcAddr),
      .regcData (regcData),
      .regaRd   (regaRd),
      .regaAddr (regaAddr),
      .regbRd   (regbRd),
      .regbAddr (regbAddr),
      .regaData (regaData),
      .regbData (regbData),
      .wbCount  (wbCount)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: architectural register contents, the write waiting to
   // commit on the next edge, and the number of committed writes.
   logic [31:0] m_mem [32];
   logic        p_wr;
   logic [4:0]  p_addr;
   logic [31:0] p_data;
   logic [31:0] m_cnt;

   typedef struct {
      logic        wr;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        ard;
      logic [4:0]  aaddr;
      logic        brd;
      logic [4:0]  baddr;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] ecnt;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic rd, input logic [4:0] a);
      if (!rd || a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
      if (regcWr && regcAddr == a) return regcData;
      if (p_wr && p_addr == a) return p_data;
`endif
      return m_mem[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
      p_wr   = 1'b0;
      p_addr = 5'd0;
      p_data = 32'd0;
      m_cnt  = 32'd0;
   endtask

   // One clock: the write sampled at the previous edge commits now, and the
   // current EX inputs become the pending write.
   task automatic tick();
      @(posedge clk);
      if (p_wr && p_addr != 5'd0) begin
         m_mem[p_addr] = p_data;
         m_cnt         = m_cnt + 32'd1;
      end
      p_wr   = regcWr;
      p_addr = regcAddr;
      p_data = regcData;
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      #1;
      check({tag, "_a"},   regaData, m_read(regaRd, regaAddr));
      check({tag, "_b"},   regbData, m_read(regbRd, regbAddr));
      check({tag, "_cnt"}, wbCount,  m_cnt);
   endtask

   initial begin
      rst_n    = 1'b0;
      regcWr   = 1'b0;
      regcAddr = 5'd0;
      regcData = 32'd0;
      regaRd   = 1'b0;
      regaAddr = 5'd0;
      regbRd   = 1'b0;
      regbAddr = 5'd0;
      model_reset();

      // Register reads stay clear of any in-flight write target, so these
      // expectations hold with or without forwarding.
      tbl[0] = '{1'b1, 5'd5,  32'h12345678, 1'b1, 5'd1,  1'b1, 5'd2,  32'h0,        32'h0,        32'd0};
      tbl[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd3,  32'h0,        32'h0,        32'd0};
      tbl[2] = '{1'b0, 5'd9,  32'h0000DEAD, 1'b1, 5'd5,  1'b0, 5'd5,  32'h12345678, 32'h0,        32'd1};
      tbl[3] = '{1'b1, 5'd7,  32'h00000001, 1'b1, 5'd5,  1'b1, 5'd5,  32'h12345678, 32'h12345678, 32'd1};
      tbl[4] = '{1'b1, 5'd7,  32'h00000002, 1'b1, 5'd9,  1'b1, 5'd0,  32'h0,        32'h0,        32'd1};
      tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b1, 5'd2,  32'h0,        32'h0,        32'd2};
      tbl[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'h2,        32'h2,        32'd3};
      tbl[7] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd7,  1'b1, 5'd30, 32'h2,        32'h0,        32'd3};
      tbl[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 1'b1, 5'd6,  32'h0,        32'h0,        32'd3};
      tbl[9] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd7,  32'hA5A5A5A5, 32'h2,        32'd4};

      #12;
      @(negedge clk);
      rst_n = 1'b1;

      // Everything reads zero after reset.
      regaRd = 1'b1;
      regbRd = 1'b1;
      for (int i = 0; i < 32; i++) begin
         regaAddr = 5'(i);
         regbAddr = 5'(31 - i);
         #1;
         check("rst_rd_a", regaData, 32'd0);
         check("rst_rd_b", regbData, 32'd0);
      end
      check("rst_cnt", wbCount, 32'd0);

      // Directed table.
      for (int v = 0; v < 10; v++) begin
         regcWr   = tbl[v].wr;
         regcAddr = tbl[v].waddr;
         regcData = tbl[v].wdata;
         regaRd   = tbl[v].ard;
         regaAddr = tbl[v].aaddr;
         regbRd   = tbl[v].brd;
         regbAddr = tbl[v].baddr;
         #1;
         check($sformatf("tbl%0d_a", v),   regaData, tbl[v].ea);
         check($sformatf("tbl%0d_b", v),   regbData, tbl[v].eb);
         check($sformatf("tbl%0d_cnt", v), wbCount,  tbl[v].ecnt);
         tick();
      end

`ifdef WB_BYPASS_EN
      // Forwarding: same-cycle from EX, next cycle from stage, EX beats stage.
      regcWr = 1'b1; regcAddr = 5'd12; regcData = 32'h12345678;
      regaRd = 1'b1; regaAddr = 5'd12;
      #1 check("byp_ex", regaData, 32'h12345678);
      tick();
      regcWr = 1'b0;
      #1 check("byp_stage", regaData, 32'h12345678);
      tick();
      regcWr = 1'b1; regcAddr = 5'd13; regcData = 32'd1;
      tick();
      regcData = 32'd2; regaAddr = 5'd13;
      #1 check("byp_ex_wins", regaData, 32'd2);
      tick();
      regcWr = 1'b0;
      tick();
`endif

      // Random traffic against the model, biased onto few registers so that
      // repeated and back-to-back writes to the same address are common.
      for (int c = 0; c < 400; c++) begin
         regcWr   = 1'($urandom_range(0, 1));
         regcAddr = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 5));
         regcData = $urandom;
         regaRd   = 1'($urandom_range(0, 3) != 0);
         regaAddr = 5'($urandom_range(0, 5));
         regbRd   = 1'($urandom_range(0, 3) != 0);
         regbAddr = 5'($urandom_range(0, 31));
         check_model("rnd");
         tick();
      end

      // Reset in mid-cycle while the stage holds r3 = 0xAA.
      regcWr = 1'b1; regcAddr = 5'd3; regcData = 32'h000000AA;
      tick();
      regcData = 32'h00000055;
      regaRd = 1'b1; regaAddr = 5'd3;
      regbRd = 1'b1; regbAddr = 5'd3;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_a",   regaData, 32'd0);
      check("mid_rst_b",   regbData, 32'd0);
      check("mid_rst_cnt", wbCount,  32'd0);
      for (int i = 1; i < 32; i++) begin
         regaAddr = 5'(i);
         #1 check("in_rst_rd", regaData, 32'd0);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      regcWr = 1'b0;
      regaAddr = 5'd3;
      model_reset();
      tick();
      tick();
      #1;
      check("post_rst_r3",  regaData, 32'd0);
      check("post_rst_cnt", wbCount,  32'd0);

      // Counter wrap.
      force dut.wb_count = 32'hFFFFFFFF;
      #1 release dut.wb_count;
      m_cnt    = 32'hFFFFFFFF;
      regcWr   = 1'b1; regcAddr = 5'd4; regcData = 32'd1;
      tick();
      regcWr   = 1'b0;
      tick();
      regaAddr = 5'd4;
      #1;
      check("wrap_cnt", wbCount,  32'd0);
      check("wrap_r4",  regaData, 32'd1);
      check_model("wrap_model");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
